// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, per-channel debounce FSM, press/release pulses, run_en toggle.
// Optional auto-repeat of press pulses is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int START_BTN       = 0,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 1250000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic               run_en
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (START_BTN < 0 || START_BTN >= NUM_BTN) begin : g_bad_start
    $error("btn_debounce: START_BTN out of range");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);
`endif

  // Polarity is normalised before the synchroniser so "released" is always 0.
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic               run_en_q;

  assign lvl = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= lvl;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          prs_q, prs_d;
    logic          rel_q, rel_d;
    logic          enter_held;
    logic          s;

    assign s = sync2_q[i];

    always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      lvl_d      = lvl_q;
      rel_d      = 1'b0;
      enter_held = 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (s) begin
            st_d  = ST_PRESS_CHK;
            cnt_d = '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!s) begin
            st_d = ST_IDLE;
          end else if (cnt_q == CNT_MAX) begin
            st_d       = ST_HELD;
            lvl_d      = 1'b1;
            enter_held = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HELD: begin
          if (!s) begin
            st_d  = ST_RELEASE_CHK;
            cnt_d = '0;
          end
        end
        ST_RELEASE_CHK: begin
          if (s) begin
            st_d = ST_HELD;
          end else if (cnt_q == CNT_MAX) begin
            st_d  = ST_IDLE;
            lvl_d = 1'b0;
            rel_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    if (i == START_BTN) begin : g_norpt
      assign prs_d = enter_held;
    end else begin : g_rpt
      // Down-counter: reloads on acceptance, freezes outside HELD so a bounce resumes the cadence.
      logic [RW-1:0] rpt_q, rpt_d;
      logic          rpt_fire;
      logic          stay_held;

      assign stay_held = (st_q == ST_HELD) && s;

      always_comb begin
        rpt_d    = rpt_q;
        rpt_fire = 1'b0;
        if (enter_held) begin
          rpt_d = RPT_FIRST;
        end else if (stay_held) begin
          if (rpt_q == '0) begin
            rpt_fire = 1'b1;
            rpt_d    = RPT_NEXT;
          end else begin
            rpt_d = rpt_q - RW'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) rpt_q <= '0;
        else     rpt_q <= rpt_d;
      end

      assign prs_d = enter_held | rpt_fire;
    end
`else
    assign prs_d = enter_held;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
      end
    end

    assign btn_level[i]     = lvl_q;
    assign press_pulse[i]   = prs_q;
    assign release_pulse[i] = rel_q;
  end

  // The start channel never auto-repeats, so every pulse on it is a genuine press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_en_q <= 1'b0;
    else     run_en_q <= run_en_q ^ press_pulse[START_BTN];
  end

  assign run_en = run_en_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (DEBOUNCE_CYCLES=4, active-low pins, 4 channels).
module tb_btn_debounce;

  localparam int DB  = 4;
  localparam int RD  = 8;
  localparam int RP  = 3;
  localparam int LAT = DB + 3;  // drive at negedge c -> pulse visible at negedge of edge c+1+2+DB

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic       run_en;

  btn_debounce #(
    .NUM_BTN(4), .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(1), .START_BTN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .run_en(run_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] prs;
    logic [3:0] rel;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  cyc = 0;
  int  hi1 = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (btn_level[1]) hi1 <= hi1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int t, input logic [3:0] p, input logic [3:0] r);
    ev_t e;
    e.cyc = t; e.prs = p; e.rel = r;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] v, output int c);
    @(negedge clk);
    btn_raw = v;
    c = cyc;
  endtask

  // Any pulse must match the oldest expected event; stale expectations count as missed.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missed_event_cycle", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if ((press_pulse | release_pulse) != 4'h0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'({press_pulse, release_pulse}), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("event_press", 32'(press_pulse), 32'(mon_e.prs));
          chk("event_release", 32'(release_pulse), 32'(mon_e.rel));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, c2, h0;
    rst = 1'b1;
    btn_raw = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_press", 32'(press_pulse), 32'h0);
    chk("rst_release", 32'(release_pulse), 32'h0);
    chk("rst_run_en", 32'(run_en), 32'h0);
    rst = 1'b0;
    c = cyc;
    push(c + LAT, 4'hF, 4'h0);
    repeat (8) @(negedge clk);
    chk("post_rst_level", 32'(btn_level), 32'hF);
    chk("post_rst_run_en", 32'(run_en), 32'h1);
    drive(4'hF, c);
    push(c + LAT, 4'h0, 4'hF);
    repeat (10) @(negedge clk);
    chk("all_released_level", 32'(btn_level), 32'h0);

    // clean press/release on ch1
    h0 = hi1;
    drive(4'b1101, c);
    push(c + LAT, 4'b0010, 4'h0);
    repeat (19) @(negedge clk);
    drive(4'hF, c2);
    push(c2 + LAT, 4'h0, 4'b0010);
    repeat (10) @(negedge clk);
    chk("ch1_high_cycles", 32'(hi1 - h0), 32'd20);
    chk("ch1_run_en_kept", 32'(run_en), 32'h1);

    // short glitch on ch2, then a bouncy 20-cycle press
    drive(4'b1011, c);
    repeat (2) @(negedge clk);
    drive(4'hF, c2);
    repeat (12) @(negedge clk);
    chk("glitch_level", 32'(btn_level), 32'h0);
    drive(4'b1011, c);
    push(c + LAT, 4'b0100, 4'h0);
    repeat (8) @(negedge clk);
    drive(4'hF, c2);
    @(negedge clk);
    drive(4'b1011, c2);
    repeat (8) @(negedge clk);
    drive(4'hF, c2);
    push(c2 + LAT, 4'h0, 4'b0100);
    repeat (10) @(negedge clk);
    chk("bounce_level", 32'(btn_level), 32'h0);

    // start toggle
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("toggle_rst_run_en", 32'(run_en), 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(4'b1110, c);
      push(c + LAT, 4'b0001, 4'h0);
      repeat (9) @(negedge clk);
      chk("toggle_run_en", 32'(run_en), (k % 2 == 0) ? 32'h1 : 32'h0);
      drive(4'hF, c);
      push(c + LAT, 4'h0, 4'b0001);
      repeat (10) @(negedge clk);
    end
    drive(4'b1110, c);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_run_en", 32'(run_en), 32'h0);
    chk("async_rst_level", 32'(btn_level), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    push(c + LAT, 4'b0001, 4'h0);
    repeat (9) @(negedge clk);
    chk("repress_run_en", 32'(run_en), 32'h1);
    drive(4'hF, c);
    push(c + LAT, 4'h0, 4'b0001);
    repeat (10) @(negedge clk);

`ifdef BTN_AUTOREPEAT_EN
    // ch3 held 30 cycles: acceptance, then RD later, then every RP while still held
    drive(4'b0111, c);
    push(c + LAT, 4'b1000, 4'h0);
    for (int t = c + LAT + RD; t <= c + 30 + 2; t += RP) push(t, 4'b1000, 4'h0);
    repeat (29) @(negedge clk);
    drive(4'hF, c2);
    push(c2 + LAT, 4'h0, 4'b1000);
    repeat (10) @(negedge clk);
    chk("rpt_ch3_run_en", 32'(run_en), 32'h1);
    drive(4'b1110, c);
    push(c + LAT, 4'b0001, 4'h0);
    repeat (29) @(negedge clk);
    drive(4'hF, c2);
    push(c2 + LAT, 4'h0, 4'b0001);
    repeat (10) @(negedge clk);
    chk("rpt_ch0_run_en", 32'(run_en), 32'h0);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream input stage for vga_pong: conditions raw push-button pins (paddle up/down per player, start/pause) into clean, synchronous, debounced levels and single-cycle press/release pulses.
- Runs on the PLL pixel clock.
- Also produces run_en, a start/pause toggle that gates game updates in vga_pong.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a level change; 10 ms at 25 MHz; must be >= 2.
- BTN_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; inputs are inverted before synchronising.
- START_BTN, 0, index of the channel whose press toggles run_en.
- REPEAT_DELAY, 6250000, auto-repeat: cycles held before the first repeat pulse (optional feature only).
- REPEAT_PERIOD, 1250000, auto-repeat: cycles between later repeat pulses (optional feature only).

Ports:
- clk  input  1  pixel clock from PLL c0.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  NUM_BTN  raw, asynchronous button pins.
- btn_level  output  NUM_BTN  debounced pressed level, 1 = pressed.
- press_pulse  output  NUM_BTN  one-cycle pulse on an accepted press (and on repeats if enabled).
- release_pulse  output  NUM_BTN  one-cycle pulse on an accepted release.
- run_en  output  1  start/pause state, toggled by START_BTN presses.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0; every channel FSM in IDLE; all counters 0; synchroniser flops hold the "released" level (logical 0 after polarity normalisation).
- Asserting rst mid-operation clears all state immediately. Any pulse in flight is dropped.
- After rst deasserts, a button that is still held is debounced again from IDLE and produces a fresh press_pulse.
- Input path, per channel:
  - lvl = btn_raw XOR BTN_ACTIVE_LOW.
  - lvl passes through a 2-flop synchroniser; the FSM uses only the second flop (s).
- Per-channel FSM (channels are fully independent); counter width $clog2(DEBOUNCE_CYCLES):
  - IDLE: if s==1, go to PRESS_CHK and set cnt=0.
  - PRESS_CHK: if s==0, go to IDLE (glitch rejected, no pulse). Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to HELD; else cnt++.
  - HELD: if s==0, go to RELEASE_CHK and set cnt=0.
  - RELEASE_CHK: if s==1, go to HELD (no pulse). Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to IDLE; else cnt++.
- Outputs are registered:
  - PRESS_CHK->HELD: btn_level goes to 1, and press_pulse is high for exactly 1 cycle.
  - RELEASE_CHK->IDLE: btn_level goes to 0, and release_pulse is high for exactly 1 cycle.
- Latency: press_pulse and the btn_level rise appear after clock edge E0+2+DEBOUNCE_CYCLES, where E0 is the first edge that samples the raw press. Release has the same latency.
- Glitch rejection: a level held for fewer than DEBOUNCE_CYCLES+1 synchronised cycles never changes btn_level.
- run_en toggles in the cycle after each debounced press_pulse[START_BTN] that comes from PRESS_CHK. Repeat pulses never toggle run_en.
- Simultaneous events: several channels may pulse in the same cycle. press_pulse and release_pulse are never both high on one channel.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- When defined, each channel has a repeat counter:
  - The counter clears on entry to HELD from PRESS_CHK and runs while in HELD.
  - It holds its value in RELEASE_CHK and resumes if the FSM returns to HELD.
  - An extra one-cycle press_pulse fires when the counter reaches REPEAT_DELAY-1, then every REPEAT_PERIOD cycles after that.
  - The channel given by START_BTN never auto-repeats.
- When not defined: no repeat logic is built, press_pulse fires once per debounced press, and REPEAT_* are ignored.

Test Plan:
- Bench settings: DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1, NUM_BTN=4.
- Reset: hold rst with btn_raw=4'b0000 (all pressed) -> all outputs 0. After release, all four press_pulse bits fire in one cycle, 6 edges after the first sampling edge; btn_level=4'hF; run_en=1.
- Clean press/release on ch1: drive btn_raw[1]=0 for 20 cycles, then 1 -> press_pulse[1] fires once 6 edges after the press; release_pulse[1] fires once 6 edges after the release; btn_level[1] is high for exactly 20 cycles; run_en unchanged.
- Glitches on ch2: a low pulse 3 cycles wide -> no pulse and btn_level stays 0. A 20-cycle press with a 2-cycle bounce high in the middle -> exactly one press_pulse and one release_pulse.
- Start toggle: press ch0 three times -> run_en reads 1, 0, 1. An async rst mid-press clears run_en to 0 within the same cycle.
- Auto-repeat (BTN_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3): hold ch3 for 30 cycles -> press_pulse[3] at acceptance, then 8 cycles later, then every 3 cycles until release. Holding ch0 the same way gives one pulse only.
